// File: rtl/serial_subtract.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_subtract #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
    logic             r_bout;
    logic [CNT_W-1:0] r_cnt;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_diff_bit;
    logic             w_next_br;
    logic             w_last;
    logic             w_accept;

    assign w_a_bit    = r_a_sh[0];
    assign w_b_bit    = r_b_sh[0];
    assign w_diff_bit = w_a_bit ^ w_b_bit ^ r_br;
    assign w_next_br  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // A start seen while RUN is dropped so the operation in flight is untouched.
    assign w_accept   = start && (r_state != RUN);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_br      <= 1'b0;
            r_cnt     <= '0;
            r_d       <= '0;
            r_bout    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_diff_sh <= '0;
            r_br      <= bin;
            r_cnt     <= '0;
        end else if (r_state == RUN) begin
            r_a_sh    <= r_a_sh >> 1;
            r_b_sh    <= r_b_sh >> 1;
            r_diff_sh <= {w_diff_bit, r_diff_sh[WIDTH-1:1]};
            r_br      <= w_next_br;
            r_cnt     <= r_cnt + 1'b1;
            // Only the completion edge publishes, so d never shows a partial result.
            if (w_last) begin
                r_d    <= {w_diff_bit, r_diff_sh[WIDTH-1:1]};
                r_bout <= w_next_br;
            end
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic r_ovf;

    // On the last RUN edge the shifted-down operand bits are the sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (!w_accept && (r_state == RUN) && w_last) begin
            r_ovf <= (w_a_bit != w_b_bit) && (w_diff_bit != w_a_bit);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign d    = r_d;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtract.sv
// Scoreboard bench for serial_subtract: directed WIDTH=8 vectors plus exhaustive WIDTH=4.
// Build with SUB_OVERFLOW_EN defined to also check ovf.
module tb_serial_subtract;

    logic       clk = 1'b0;
    logic       rst;
    logic       start,  start4;
    logic [7:0] a, b;
    logic [3:0] a4, b4;
    logic       bin, bin4;
    logic       busy, done, bout;
    logic       busy4, done4, bout4;
    logic [7:0] d;
    logic [3:0] d4;
`ifdef SUB_OVERFLOW_EN
    logic       ovf, ovf4;
`endif

    always #5 clk = ~clk;

    serial_subtract #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    serial_subtract #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (q8.size() == 0) begin
                check("dut8_unexpected_done", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("dut8_d", d, e8.d);
                check("dut8_bout", bout, e8.bout);
                check("dut8_latency", cyc, e8.cyc);
`ifdef SUB_OVERFLOW_EN
                check("dut8_ovf", ovf, e8.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_done", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("dut4_d", d4, e4.d);
                check("dut4_bout", bout4, e4.bout);
                check("dut4_latency", cyc, e4.cyc);
`ifdef SUB_OVERFLOW_EN
                check("dut4_ovf", ovf4, e4.ovf);
`endif
            end
        end
    end

    // Called on a falling edge; start is sampled on the following rising edge.
    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          input logic [7:0] ed, input logic eb, input logic eo);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        q8.push_back('{d: ed, bout: eb, ovf: eo, cyc: cyc + 1 + 8});
        @(negedge clk);
        start = 1'b0;
        a = ~ia; b = ~ib; bin = ~ibin;
        check("dut8_busy_after_start", busy, 32'd1);
    endtask

    task automatic wait_done8();
        int i = 0;
        while (!done && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!done) check("dut8_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin);
        logic [4:0] r;
        r = {1'b0, ia} - {1'b0, ib} - {4'd0, ibin};
        a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
        q4.push_back('{d: {4'd0, r[3:0]}, bout: r[4],
                       ovf: (ia[3] != ib[3]) && (r[3] != ia[3]), cyc: cyc + 1 + 4});
        @(negedge clk);
        start4 = 1'b0;
        a4 = ~ia; b4 = ~ib;
        check("dut4_busy_after_start", busy4, 32'd1);
    endtask

    task automatic wait_done4();
        int i = 0;
        while (!done4 && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (!done4) check("dut4_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(negedge clk);
        // Reset wins over a simultaneous start.
        start = 1'b1; a = 8'h12; b = 8'h34;
        @(negedge clk);
        start = 1'b0;
        check("reset_busy", busy, 32'd0);
        check("reset_done", done, 32'd0);
        check("reset_d", d, 32'h00);
        check("reset_bout", bout, 32'd0);
        check("reset_busy4", busy4, 32'd0);
`ifdef SUB_OVERFLOW_EN
        check("reset_ovf", ovf, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset_busy", busy, 32'd0);

        issue8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        wait_done8();
        @(negedge clk);
        check("done_one_cycle", done, 32'd0);

        // Second op starts in the DONE cycle of the first.
        issue8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        wait_done8();
        issue8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        wait_done8();
        @(negedge clk);

        issue8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        wait_done8();
        issue8(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);
        wait_done8();
        issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        wait_done8();
        issue8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        wait_done8();
        repeat (3) @(negedge clk);
        check("hold_d", d, 32'h80);
        check("hold_bout", bout, 32'd1);
        check("idle_busy", busy, 32'd0);

        // A start pulse on the 3rd RUN edge must be ignored.
        issue8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("partial_hidden_d", d, 32'h80);
        a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done8();
        repeat (12) @(negedge clk);
        check("ignored_start_no_busy", busy, 32'd0);

        // Reset on the 4th RUN edge aborts without a done pulse.
        a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 32'd0);
        check("abort_done", done, 32'd0);
        check("abort_d", d, 32'h00);
        check("abort_bout", bout, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_still_idle", busy, 32'd0);

        issue8(8'h0A, 8'h14, 1'b0, 8'hF6, 1'b1, 1'b0);
        wait_done8();
        issue8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        wait_done8();

        // Exhaustive WIDTH=4 sweep, back to back.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    issue4(4'(ia), 4'(ib), 1'(ic));
                    wait_done4();
                end
            end
        end

        repeat (12) @(negedge clk);
        check("q8_drained", q8.size(), 32'd0);
        check("q4_drained", q4.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtract.md
SERIAL_SUBTRACT -- requirements
Module: serial_subtract

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on a rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, sampled with start.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port d, output, WIDTH bits: difference, a - b - bin modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: borrow-out, 1 when a < b + bin (unsigned).
REQ-012 The block SHALL have port ovf, output, 1 bit, present only when SUB_OVERFLOW_EN is defined (see REQ-027).

Function
REQ-013 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, start=1 SHALL latch a, b and bin into internal shift registers, set the borrow flip-flop to bin, clear the bit counter, and go to RUN.
REQ-015 In RUN, each edge SHALL process one bit, LSB first: diff bit = a_i XOR b_i XOR br; next br = (~a_i & b_i) | (~(a_i XOR b_i) & br).
REQ-016 The bit counter SHALL run 0..WIDTH-1; the edge that processes bit WIDTH-1 SHALL load d and bout from the completed result, set done=1 and go to DONE.
REQ-017 Latency SHALL be exactly WIDTH rising edges from the edge sampling start to the edge asserting done.
REQ-018 busy SHALL be 1 exactly while the state is RUN.
REQ-019 done SHALL be high for exactly one cycle; DONE with no start SHALL return to IDLE on the next edge.
REQ-020 start while in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-021 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-022 d and bout SHALL change only on the completion edge and hold their value until the next completion; partial results SHALL never be visible on d.
REQ-023 Changes on a, b and bin outside the start edge SHALL have no effect.

Reset
REQ-024 rst=1 on a rising edge SHALL force IDLE, clear the counter, shift registers and borrow flip-flop, and drive busy=0, done=0, d=0, bout=0 (and ovf=0 if present).
REQ-025 rst SHALL take priority over start in the same cycle.
REQ-026 rst during RUN SHALL abort the operation with no done pulse and no result update.

Configuration
REQ-027 With SUB_OVERFLOW_EN defined, ovf SHALL be registered on the completion edge as the two's-complement signed overflow (a[W-1] != b[W-1] and d[W-1] != a[W-1]) and held like d; without the macro the port and its logic SHALL be absent and every other behaviour SHALL be unchanged.

Verification
REQ-028 WIDTH=8, a=0x05, b=0x03, bin=0 -> after 8 edges done=1, d=0x02, bout=0.
REQ-029 WIDTH=8, a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1; then a=0x10, b=0x0F, bin=1 started in the DONE cycle -> d=0x00, bout=0 exactly 8 edges later.
REQ-030 WIDTH=8 with SUB_OVERFLOW_EN defined: a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1; a=0x7F, b=0x01 -> d=0x7E, ovf=0.
REQ-031 Start a=0x33, b=0x11, then pulse start with a=0xFF, b=0x00 at the 3rd RUN edge -> result d=0x22, no extra done pulse.
REQ-032 Assert rst at the 4th RUN edge -> busy=0, done stays 0, d and bout read 0; the next start completes normally.
REQ-033 WIDTH=4: run all 512 combinations of a, b and bin against a golden model of a-b-bin -> d and bout match every case.
